// File: rtl/fpu_rsp_rob.sv
// ---------------------------------------------------------------------------
// fpu_rsp_rob
//   Request tag allocator and response reorder buffer for one FPU block, with
//   per-warp fflags accumulation. It sits between the block's execute
//   handshake and its commit path.
//   IN_ORDER=1 : tags are handed out round-robin. Results are parked in their
//                slots and commit strictly in allocation order, one cycle or
//                more after they return.
//   IN_ORDER=0 : tags are the lowest free slot. Results pass straight through
//                to commit with zero latency. Only the request metadata is
//                stored.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_*                   execute request handshake; req_tag is the slot granted
//   exe_*                   FPU core result return, addressed by exe_tag
//   cmt_*                   commit handshake carrying metadata and result
//   csr_we/csr_wid/csr_fflags  fflags CSR write, one strobe per eop commit
//   count/full/empty        occupancy
// ---------------------------------------------------------------------------
module fpu_rsp_rob #(
    parameter int SIZE      = 8,
    parameter int NUM_LANES = 4,
    parameter int META_W    = 64,
    parameter int NUM_WARPS = 4,
    parameter int IN_ORDER  = 1,
    localparam int TAG_WIDTH = $clog2(SIZE),
    localparam int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RESULT_W  = NUM_LANES * 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [META_W-1:0]    req_meta,
    input  logic [NW_BITS-1:0]   req_wid,
    input  logic                 req_sop,
    input  logic                 req_eop,
    output logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 exe_valid,
    output logic                 exe_ready,
    input  logic [TAG_WIDTH-1:0] exe_tag,
    input  logic [RESULT_W-1:0]  exe_result,
    input  logic                 exe_has_fflags,
    input  logic [4:0]           exe_fflags,
    output logic                 cmt_valid,
    input  logic                 cmt_ready,
    output logic [META_W-1:0]    cmt_meta,
    output logic [NW_BITS-1:0]   cmt_wid,
    output logic                 cmt_sop,
    output logic                 cmt_eop,
    output logic [RESULT_W-1:0]  cmt_result,
    output logic                 csr_we,
    output logic [NW_BITS-1:0]   csr_wid,
    output logic [4:0]           csr_fflags,
    output logic [TAG_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam bit ORDERED = (IN_ORDER != 0);

    // Per-slot storage
    logic [META_W-1:0]    r_meta   [SIZE];
    logic [NW_BITS-1:0]   r_wid    [SIZE];
    logic [RESULT_W-1:0]  r_result [SIZE];
    logic [4:0]           r_ff     [SIZE];
    logic [SIZE-1:0]      r_sop, r_eop, r_has;
    logic [SIZE-1:0]      r_busy, r_done;

    logic [TAG_WIDTH-1:0] r_head, r_tail;
    logic [TAG_WIDTH:0]   r_count;

    // Per-warp fflags accumulators
    logic [4:0]           r_acc_ff [NUM_WARPS];
    logic [NUM_WARPS-1:0] r_acc_has;

    logic [TAG_WIDTH-1:0] w_free_idx, w_alloc_tag, w_cmt_idx;
    logic                 w_full, w_req_fire, w_exe_fire, w_cmt_fire;
    logic                 w_cmt_has, w_acc_has;
    logic [4:0]           w_cmt_ff, w_acc_ff;

    // Lowest-index free slot. The scan runs from the top down, so the last hit wins.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment. Otherwise a path that leaves it unassigned infers a latch.
    always_comb begin
        w_free_idx = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = TAG_WIDTH'(i);
        end
    end

    assign w_full      = (r_count == (TAG_WIDTH + 1)'(SIZE));
    // While full, no request is accepted, even in a cycle where a commit frees a slot.
    assign req_ready   = ~w_full;
    assign w_alloc_tag = ORDERED ? r_tail : w_free_idx;
    assign req_tag     = w_alloc_tag;
    assign w_req_fire  = req_valid & req_ready;

    assign exe_ready   = ORDERED ? 1'b1 : cmt_ready;
    assign w_exe_fire  = exe_valid & exe_ready;

    // The commit source is the head slot when ordered, and the returning tag when pass-through.
    assign w_cmt_idx   = ORDERED ? r_head : exe_tag;
    assign cmt_valid   = ORDERED ? (r_busy[r_head] & r_done[r_head]) : exe_valid;
    assign cmt_meta    = r_meta[w_cmt_idx];
    assign cmt_wid     = r_wid[w_cmt_idx];
    assign cmt_sop     = r_sop[w_cmt_idx];
    assign cmt_eop     = r_eop[w_cmt_idx];
    assign cmt_result  = ORDERED ? r_result[r_head] : exe_result;
    assign w_cmt_has   = ORDERED ? r_has[r_head] : exe_has_fflags;
    assign w_cmt_ff    = ORDERED ? r_ff[r_head] : exe_fflags;
    assign w_cmt_fire  = cmt_valid & cmt_ready;

    // Fold this commit's flags into its warp. The CSR write happens on eop, and only if any packet carried flags.
    assign w_acc_ff    = r_acc_ff[cmt_wid] | (w_cmt_has ? w_cmt_ff : 5'd0);
    assign w_acc_has   = r_acc_has[cmt_wid] | w_cmt_has;
    assign csr_we      = w_cmt_fire & cmt_eop & w_acc_has;
    assign csr_wid     = cmt_wid;
    assign csr_fflags  = w_acc_ff;

    assign count       = r_count;
    assign full        = w_full;
    assign empty       = (r_count == '0);

    // Control state: slot flags, pointers, occupancy and accumulators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy    <= '0;
            r_done    <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_acc_has <= '0;
            for (int w = 0; w < NUM_WARPS; w++) r_acc_ff[w] <= '0;
        end else begin
            // Free runs before alloc, so a slot freed and re-granted in the same cycle ends up busy.
            if (w_cmt_fire) begin
                r_busy[w_cmt_idx] <= 1'b0;
                r_done[w_cmt_idx] <= 1'b0;
                if (ORDERED) r_head <= r_head + TAG_WIDTH'(1);
                if (cmt_eop) begin
                    r_acc_ff[cmt_wid]  <= '0;
                    r_acc_has[cmt_wid] <= 1'b0;
                end else begin
                    r_acc_ff[cmt_wid]  <= w_acc_ff;
                    r_acc_has[cmt_wid] <= w_acc_has;
                end
            end
            if (ORDERED && w_exe_fire) r_done[exe_tag] <= 1'b1;
            if (w_req_fire) begin
                r_busy[w_alloc_tag] <= 1'b1;
                r_done[w_alloc_tag] <= 1'b0;
                if (ORDERED) r_tail <= r_tail + TAG_WIDTH'(1);
            end
            if (w_req_fire && !w_cmt_fire)      r_count <= r_count + (TAG_WIDTH + 1)'(1);
            else if (!w_req_fire && w_cmt_fire) r_count <= r_count - (TAG_WIDTH + 1)'(1);
        end
    end

    // NOTE: the slot payload is not reset. The busy/done flags alone say
    // whether a slot holds anything, and clearing wide RAM-like arrays on
    // reset would only cost routing.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_meta[w_alloc_tag] <= req_meta;
            r_wid[w_alloc_tag]  <= req_wid;
            r_sop[w_alloc_tag]  <= req_sop;
            r_eop[w_alloc_tag]  <= req_eop;
        end
        if (ORDERED && w_exe_fire) begin
            r_result[exe_tag] <= exe_result;
            r_ff[exe_tag]     <= exe_fflags;
            r_has[exe_tag]    <= exe_has_fflags;
        end
    end

    // A stalled request must be held unchanged until it is accepted.
    a_req_hold : assert property (@(posedge clk) disable iff (!reset_n)
        (req_valid && !req_ready) |=>
        (req_valid && $stable(req_meta) && $stable(req_wid) && $stable(req_sop) && $stable(req_eop)));

    // A result may only return to an allocated slot that has not already returned.
    a_exe_slot : assert property (@(posedge clk) disable iff (!reset_n)
        w_exe_fire |-> (r_busy[exe_tag] && !r_done[exe_tag]));

endmodule

// File: tb/tb_fpu_rsp_rob.sv
// ---------------------------------------------------------------------------
// tb_fpu_rsp_rob
//   Drives two instances: u_ord (IN_ORDER=1) and u_ooo (IN_ORDER=0).
//   Directed scenarios cover reset, reorder, full/wrap, fflags accumulation,
//   pass-through backpressure and commits without fflags. Randomized runs
//   compare both instances against a queue/array reference model.
//   Inputs change at the falling edge. Outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fpu_rsp_rob;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // In-order instance signals
    logic         a_req_valid, a_req_ready, a_req_sop, a_req_eop;
    logic [63:0]  a_req_meta;
    logic [1:0]   a_req_wid;
    logic [2:0]   a_req_tag;
    logic         a_exe_valid, a_exe_ready, a_exe_has_fflags;
    logic [2:0]   a_exe_tag;
    logic [127:0] a_exe_result;
    logic [4:0]   a_exe_fflags;
    logic         a_cmt_valid, a_cmt_ready, a_cmt_sop, a_cmt_eop;
    logic [63:0]  a_cmt_meta;
    logic [1:0]   a_cmt_wid;
    logic [127:0] a_cmt_result;
    logic         a_csr_we;
    logic [1:0]   a_csr_wid;
    logic [4:0]   a_csr_fflags;
    logic [3:0]   a_count;
    logic         a_full, a_empty;

    // Out-of-order instance signals
    logic         b_req_valid, b_req_ready, b_req_sop, b_req_eop;
    logic [63:0]  b_req_meta;
    logic [1:0]   b_req_wid;
    logic [2:0]   b_req_tag;
    logic         b_exe_valid, b_exe_ready, b_exe_has_fflags;
    logic [2:0]   b_exe_tag;
    logic [127:0] b_exe_result;
    logic [4:0]   b_exe_fflags;
    logic         b_cmt_valid, b_cmt_ready, b_cmt_sop, b_cmt_eop;
    logic [63:0]  b_cmt_meta;
    logic [1:0]   b_cmt_wid;
    logic [127:0] b_cmt_result;
    logic         b_csr_we;
    logic [1:0]   b_csr_wid;
    logic [4:0]   b_csr_fflags;
    logic [3:0]   b_count;
    logic         b_full, b_empty;

    fpu_rsp_rob #(.SIZE(8), .NUM_LANES(4), .META_W(64), .NUM_WARPS(4), .IN_ORDER(1)) u_ord (
        .clk(clk), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_meta(a_req_meta), .req_wid(a_req_wid),
        .req_sop(a_req_sop), .req_eop(a_req_eop), .req_tag(a_req_tag),
        .exe_valid(a_exe_valid), .exe_ready(a_exe_ready), .exe_tag(a_exe_tag), .exe_result(a_exe_result),
        .exe_has_fflags(a_exe_has_fflags), .exe_fflags(a_exe_fflags),
        .cmt_valid(a_cmt_valid), .cmt_ready(a_cmt_ready), .cmt_meta(a_cmt_meta), .cmt_wid(a_cmt_wid),
        .cmt_sop(a_cmt_sop), .cmt_eop(a_cmt_eop), .cmt_result(a_cmt_result),
        .csr_we(a_csr_we), .csr_wid(a_csr_wid), .csr_fflags(a_csr_fflags),
        .count(a_count), .full(a_full), .empty(a_empty)
    );

    fpu_rsp_rob #(.SIZE(8), .NUM_LANES(4), .META_W(64), .NUM_WARPS(4), .IN_ORDER(0)) u_ooo (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_meta(b_req_meta), .req_wid(b_req_wid),
        .req_sop(b_req_sop), .req_eop(b_req_eop), .req_tag(b_req_tag),
        .exe_valid(b_exe_valid), .exe_ready(b_exe_ready), .exe_tag(b_exe_tag), .exe_result(b_exe_result),
        .exe_has_fflags(b_exe_has_fflags), .exe_fflags(b_exe_fflags),
        .cmt_valid(b_cmt_valid), .cmt_ready(b_cmt_ready), .cmt_meta(b_cmt_meta), .cmt_wid(b_cmt_wid),
        .cmt_sop(b_cmt_sop), .cmt_eop(b_cmt_eop), .cmt_result(b_cmt_result),
        .csr_we(b_csr_we), .csr_wid(b_csr_wid), .csr_fflags(b_csr_fflags),
        .count(b_count), .full(b_full), .empty(b_empty)
    );

    task automatic clear_inputs();
        a_req_valid = 0; a_req_meta = '0; a_req_wid = '0; a_req_sop = 0; a_req_eop = 0;
        a_exe_valid = 0; a_exe_tag = '0; a_exe_result = '0; a_exe_has_fflags = 0; a_exe_fflags = '0;
        a_cmt_ready = 0;
        b_req_valid = 0; b_req_meta = '0; b_req_wid = '0; b_req_sop = 0; b_req_eop = 0;
        b_exe_valid = 0; b_exe_tag = '0; b_exe_result = '0; b_exe_has_fflags = 0; b_exe_fflags = '0;
        b_cmt_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic a_alloc(input logic [63:0] meta, input logic [1:0] wid, input logic sop, input logic eop,
                           input logic [2:0] exp_tag);
        @(negedge clk);
        a_req_valid = 1; a_req_meta = meta; a_req_wid = wid; a_req_sop = sop; a_req_eop = eop;
        #1;
        n_vec++;
        if (a_req_ready !== 1'b1 || a_req_tag !== exp_tag) begin
            n_err++;
            $display("FAIL ord_alloc: ready=%b tag=%0d, want ready=1 tag=%0d", a_req_ready, a_req_tag, exp_tag);
        end
        @(posedge clk); #1;
        a_req_valid = 0;
    endtask

    task automatic b_alloc(input logic [63:0] meta, input logic [1:0] wid, input logic sop, input logic eop,
                           input logic [2:0] exp_tag);
        @(negedge clk);
        b_req_valid = 1; b_req_meta = meta; b_req_wid = wid; b_req_sop = sop; b_req_eop = eop;
        #1;
        n_vec++;
        if (b_req_ready !== 1'b1 || b_req_tag !== exp_tag) begin
            n_err++;
            $display("FAIL ooo_alloc: ready=%b tag=%0d, want ready=1 tag=%0d", b_req_ready, b_req_tag, exp_tag);
        end
        @(posedge clk); #1;
        b_req_valid = 0;
    endtask

    task automatic a_exe(input logic [2:0] tag, input logic [127:0] res, input logic has, input logic [4:0] ff);
        @(negedge clk);
        a_exe_valid = 1; a_exe_tag = tag; a_exe_result = res; a_exe_has_fflags = has; a_exe_fflags = ff;
        @(posedge clk); #1;
        a_exe_valid = 0;
    endtask

    // Reset values, then an asynchronous reset that lands with three busy slots.
    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if (a_count !== 4'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_req_ready !== 1'b1 ||
            a_cmt_valid !== 1'b0 || a_csr_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ord: count=%0d empty=%b full=%b ready=%b cmt_valid=%b csr_we=%b, want 0 1 0 1 0 0",
                     a_count, a_empty, a_full, a_req_ready, a_cmt_valid, a_csr_we);
        end
        n_vec++;
        if (b_count !== 4'd0 || b_empty !== 1'b1 || b_full !== 1'b0 || b_req_ready !== 1'b1 || b_csr_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ooo: count=%0d empty=%b full=%b ready=%b csr_we=%b, want 0 1 0 1 0",
                     b_count, b_empty, b_full, b_req_ready, b_csr_we);
        end
        for (int i = 0; i < 3; i++) a_alloc(64'h10 + 64'(i), 2'd0, 1'b1, 1'b1, 3'(i));
        a_exe(3'd0, 128'h55, 1'b0, 5'd0);
        @(negedge clk); #1;
        n_vec++;
        if (a_cmt_valid !== 1'b1 || a_count !== 4'd3) begin
            n_err++;
            $display("FAIL reset_pre: cmt_valid=%b count=%0d, want 1 3", a_cmt_valid, a_count);
        end
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if (a_count !== 4'd0 || a_empty !== 1'b1 || a_cmt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: count=%0d empty=%b cmt_valid=%b, want 0 1 0", a_count, a_empty, a_cmt_valid);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) a_alloc(64'h20 + 64'(i), 2'd0, 1'b1, 1'b1, 3'(i));
    endtask

    // Results return out of order 2,0,1; commits must come out as 0,1,2.
    task automatic test_reorder();
        logic [127:0] want [3];
        want[0] = 128'hA0; want[1] = 128'hA1; want[2] = 128'hA2;
        do_reset();
        for (int i = 0; i < 3; i++) a_alloc(64'h100 + 64'(i), 2'd0, 1'b1, 1'b1, 3'(i));
        @(negedge clk);
        a_cmt_ready = 1;
        a_exe_valid = 1; a_exe_tag = 3'd2; a_exe_result = 128'hA2;
        #1;
        n_vec++;
        if (a_cmt_valid !== 1'b0) begin n_err++; $display("FAIL reorder_wait2: cmt_valid=%b want 0", a_cmt_valid); end
        @(negedge clk);
        a_exe_tag = 3'd0; a_exe_result = 128'hA0;
        #1;
        n_vec++;
        if (a_cmt_valid !== 1'b0) begin n_err++; $display("FAIL reorder_wait0: cmt_valid=%b want 0", a_cmt_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin a_exe_tag = 3'd1; a_exe_result = 128'hA1; end
            else a_exe_valid = 0;
            #1;
            n_vec++;
            if (a_cmt_valid !== 1'b1 || a_cmt_result !== want[k] || a_cmt_meta !== 64'h100 + 64'(k)) begin
                n_err++;
                $display("FAIL reorder_commit%0d: valid=%b result=%h meta=%h, want 1 %h %h",
                         k, a_cmt_valid, a_cmt_result, a_cmt_meta, want[k], 64'h100 + 64'(k));
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if (a_cmt_valid !== 1'b0 || a_count !== 4'd0 || a_empty !== 1'b1) begin
            n_err++;
            $display("FAIL reorder_drain: valid=%b count=%0d empty=%b, want 0 0 1", a_cmt_valid, a_count, a_empty);
        end
    endtask

    // Fill all 8 slots. A commit while full must not let a request through that same cycle.
    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) a_alloc(64'h200 + 64'(i), 2'd1, 1'b1, 1'b1, 3'(i));
        @(negedge clk);
        a_exe_valid = 1; a_exe_tag = 3'd0; a_exe_result = 128'hF0;
        a_req_valid = 1; a_req_meta = 64'h2FF; a_req_wid = 2'd1; a_req_sop = 1; a_req_eop = 1;
        #1;
        n_vec++;
        if (a_full !== 1'b1 || a_req_ready !== 1'b0 || a_count !== 4'd8) begin
            n_err++;
            $display("FAIL full_flags: full=%b ready=%b count=%0d, want 1 0 8", a_full, a_req_ready, a_count);
        end
        @(negedge clk);
        a_exe_valid = 0; a_cmt_ready = 1;
        #1;
        n_vec++;
        if (a_cmt_valid !== 1'b1 || a_req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_nobypass: cmt_valid=%b ready=%b, want 1 0", a_cmt_valid, a_req_ready);
        end
        @(negedge clk);
        a_cmt_ready = 0;
        #1;
        n_vec++;
        if (a_req_ready !== 1'b1 || a_req_tag !== 3'd0 || a_full !== 1'b0 || a_count !== 4'd7) begin
            n_err++;
            $display("FAIL wrap_alloc: ready=%b tag=%0d full=%b count=%0d, want 1 0 0 7",
                     a_req_ready, a_req_tag, a_full, a_count);
        end
        @(negedge clk);
        a_req_valid = 0;
        #1;
        n_vec++;
        if (a_count !== 4'd8 || a_full !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_refill: count=%0d full=%b, want 8 1", a_count, a_full);
        end
    endtask

    // Warp 2 sends three packets, with a single-packet warp 1 instruction interleaved.
    task automatic test_fflags();
        logic [1:0] wid [4];
        logic       sop [4];
        logic       eop [4];
        logic [4:0] ff  [4];
        logic       we_w [4];
        logic [1:0] wid_w [4];
        logic [4:0] ff_w [4];
        wid[0] = 2; sop[0] = 1; eop[0] = 0; ff[0] = 5'h01; we_w[0] = 0; wid_w[0] = 2; ff_w[0] = 5'h00;
        wid[1] = 1; sop[1] = 1; eop[1] = 1; ff[1] = 5'h02; we_w[1] = 1; wid_w[1] = 1; ff_w[1] = 5'h02;
        wid[2] = 2; sop[2] = 0; eop[2] = 0; ff[2] = 5'h04; we_w[2] = 0; wid_w[2] = 2; ff_w[2] = 5'h00;
        wid[3] = 2; sop[3] = 0; eop[3] = 1; ff[3] = 5'h10; we_w[3] = 1; wid_w[3] = 2; ff_w[3] = 5'h15;
        do_reset();
        for (int i = 0; i < 4; i++) a_alloc(64'h300 + 64'(i), wid[i], sop[i], eop[i], 3'(i));
        for (int i = 0; i < 4; i++) a_exe(3'(i), 128'(i), 1'b1, ff[i]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_cmt_ready = 1;
            #1;
            n_vec++;
            if (a_cmt_valid !== 1'b1 || a_csr_we !== we_w[k] ||
                (we_w[k] && (a_csr_wid !== wid_w[k] || a_csr_fflags !== ff_w[k]))) begin
                n_err++;
                $display("FAIL fflags_commit%0d: valid=%b we=%b wid=%0d ff=%h, want 1 %b %0d %h",
                         k, a_cmt_valid, a_csr_we, a_csr_wid, a_csr_fflags, we_w[k], wid_w[k], ff_w[k]);
            end
        end
        @(negedge clk); #1;
        n_vec++;
        if (a_cmt_valid !== 1'b0 || a_csr_we !== 1'b0) begin
            n_err++;
            $display("FAIL fflags_idle: valid=%b we=%b, want 0 0", a_cmt_valid, a_csr_we);
        end
    endtask

    // An eop commit without fflags writes nothing and leaves the accumulator clear.
    task automatic test_no_fflags();
        do_reset();
        a_alloc(64'h400, 2'd3, 1'b1, 1'b1, 3'd0);
        a_exe(3'd0, 128'h1, 1'b0, 5'h1F);
        @(negedge clk);
        a_cmt_ready = 1;
        #1;
        n_vec++;
        if (a_cmt_valid !== 1'b1 || a_csr_we !== 1'b0) begin
            n_err++;
            $display("FAIL noff_we: valid=%b we=%b, want 1 0", a_cmt_valid, a_csr_we);
        end
        @(negedge clk);
        a_cmt_ready = 0;
        a_alloc(64'h401, 2'd3, 1'b1, 1'b1, 3'd1);
        a_exe(3'd1, 128'h2, 1'b1, 5'h08);
        @(negedge clk);
        a_cmt_ready = 1;
        #1;
        n_vec++;
        if (a_csr_we !== 1'b1 || a_csr_wid !== 2'd3 || a_csr_fflags !== 5'h08) begin
            n_err++;
            $display("FAIL noff_acc: we=%b wid=%0d ff=%h, want 1 3 08", a_csr_we, a_csr_wid, a_csr_fflags);
        end
        @(negedge clk);
        a_cmt_ready = 0;
    endtask

    // Pass-through mode: commit backpressure stalls the result return and keeps slot 3 held.
    task automatic test_ooo_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) b_alloc(64'h500 + 64'(i), 2'(i), 1'b1, 1'b1, 3'(i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            b_exe_valid = 1; b_exe_tag = 3'd3; b_exe_result = 128'hB3; b_cmt_ready = 0;
            #1;
            n_vec++;
            if (b_exe_ready !== 1'b0 || b_cmt_valid !== 1'b1 || b_count !== 4'd4) begin
                n_err++;
                $display("FAIL ooo_stall%0d: exe_ready=%b cmt_valid=%b count=%0d, want 0 1 4",
                         k, b_exe_ready, b_cmt_valid, b_count);
            end
        end
        @(negedge clk);
        b_cmt_ready = 1;
        #1;
        n_vec++;
        if (b_exe_ready !== 1'b1 || b_cmt_meta !== 64'h503 || b_cmt_wid !== 2'd3 || b_cmt_result !== 128'hB3) begin
            n_err++;
            $display("FAIL ooo_release: exe_ready=%b meta=%h wid=%0d result=%h, want 1 503 3 b3",
                     b_exe_ready, b_cmt_meta, b_cmt_wid, b_cmt_result);
        end
        @(negedge clk);
        b_exe_valid = 0; b_cmt_ready = 0;
        #1;
        n_vec++;
        if (b_count !== 4'd3) begin n_err++; $display("FAIL ooo_count: count=%0d want 3", b_count); end
        b_alloc(64'h5A0, 2'd0, 1'b1, 1'b1, 3'd3);
    endtask

    // Random traffic on the in-order instance against an allocation-order queue model.
    task automatic test_random_inorder();
        int q[$];
        int pl[$];
        logic [63:0]  mm [8];
        logic [1:0]   mw [8];
        logic         ms [8], me [8], mh [8];
        logic [127:0] mr [8];
        logic [4:0]   mf [8];
        bit           md [8];
        logic [4:0]   acc_f [4];
        logic         acc_h [4];
        int allocs, cyc, hd;
        bit hold, drain, full, req_fire, exp_cv, cmt_fire, exp_we;
        logic [1:0] w;
        logic [4:0] f;
        logic hh;
        do_reset();
        allocs = 0; hold = 0; cyc = 0;
        foreach (acc_f[i]) begin acc_f[i] = '0; acc_h[i] = 1'b0; end
        foreach (md[i]) md[i] = 1'b0;
        while ((cyc < 600 || hold || q.size() > 0) && cyc < 900) begin
            drain = (cyc >= 600);
            @(negedge clk);
            if (!hold) begin
                a_req_valid = !drain && ($urandom_range(0, 99) < 55);
                a_req_meta  = {$urandom, $urandom};
                a_req_wid   = 2'($urandom_range(0, 3));
                a_req_sop   = 1'($urandom_range(0, 1));
                a_req_eop   = 1'($urandom_range(0, 1));
            end
            pl.delete();
            foreach (q[i]) if (!md[q[i]]) pl.push_back(q[i]);
            a_exe_valid = (pl.size() > 0) && (drain || $urandom_range(0, 99) < 50);
            a_exe_tag = '0;
            if (a_exe_valid) a_exe_tag = 3'(pl[$urandom_range(0, pl.size() - 1)]);
            a_exe_result     = {$urandom, $urandom, $urandom, $urandom};
            a_exe_has_fflags = 1'($urandom_range(0, 1));
            a_exe_fflags     = 5'($urandom_range(0, 31));
            a_cmt_ready      = drain || ($urandom_range(0, 99) < 70);
            #1;
            full = (q.size() == 8);
            n_vec++;
            if (a_req_ready !== !full || a_count !== 4'(q.size())) begin
                n_err++;
                $display("FAIL rnd_ord_occ cyc%0d: ready=%b count=%0d, want %b %0d", cyc, a_req_ready, a_count, !full, q.size());
            end
            req_fire = a_req_valid && !full;
            if (req_fire) begin
                n_vec++;
                if (a_req_tag !== 3'(allocs % 8)) begin
                    n_err++;
                    $display("FAIL rnd_ord_tag cyc%0d: tag=%0d want %0d", cyc, a_req_tag, allocs % 8);
                end
            end
            exp_cv = (q.size() > 0) && md[q[0]];
            n_vec++;
            if (a_cmt_valid !== exp_cv) begin
                n_err++;
                $display("FAIL rnd_ord_cv cyc%0d: cmt_valid=%b want %b", cyc, a_cmt_valid, exp_cv);
            end
            cmt_fire = exp_cv && a_cmt_ready;
            exp_we = 1'b0;
            if (exp_cv) begin
                hd = q[0];
                n_vec++;
                if (a_cmt_result !== mr[hd] || a_cmt_meta !== mm[hd] || a_cmt_wid !== mw[hd] ||
                    a_cmt_sop !== ms[hd] || a_cmt_eop !== me[hd]) begin
                    n_err++;
                    $display("FAIL rnd_ord_data cyc%0d tag%0d: result=%h meta=%h wid=%0d sop=%b eop=%b, want %h %h %0d %b %b",
                             cyc, hd, a_cmt_result, a_cmt_meta, a_cmt_wid, a_cmt_sop, a_cmt_eop,
                             mr[hd], mm[hd], mw[hd], ms[hd], me[hd]);
                end
            end
            if (cmt_fire) begin
                hd = q[0];
                w  = mw[hd];
                f  = acc_f[w] | (mh[hd] ? mf[hd] : 5'd0);
                hh = acc_h[w] | mh[hd];
                exp_we = me[hd] && hh;
                if (me[hd]) begin acc_f[w] = '0; acc_h[w] = 1'b0; end
                else begin acc_f[w] = f; acc_h[w] = hh; end
                n_vec++;
                if (a_csr_we !== exp_we || (exp_we && (a_csr_wid !== w || a_csr_fflags !== f))) begin
                    n_err++;
                    $display("FAIL rnd_ord_csr cyc%0d: we=%b wid=%0d ff=%h, want %b %0d %h",
                             cyc, a_csr_we, a_csr_wid, a_csr_fflags, exp_we, w, f);
                end
                md[hd] = 1'b0;
                void'(q.pop_front());
            end else begin
                n_vec++;
                if (a_csr_we !== 1'b0) begin n_err++; $display("FAIL rnd_ord_csr_idle cyc%0d: we=%b want 0", cyc, a_csr_we); end
            end
            if (a_exe_valid) begin
                md[a_exe_tag] = 1'b1;
                mr[a_exe_tag] = a_exe_result;
                mh[a_exe_tag] = a_exe_has_fflags;
                mf[a_exe_tag] = a_exe_fflags;
            end
            if (req_fire) begin
                hd = allocs % 8;
                mm[hd] = a_req_meta; mw[hd] = a_req_wid; ms[hd] = a_req_sop; me[hd] = a_req_eop;
                md[hd] = 1'b0;
                q.push_back(hd);
                allocs++;
            end
            hold = a_req_valid && !req_fire;
            cyc++;
        end
        n_vec++;
        if (hold || q.size() != 0) begin
            n_err++;
            $display("FAIL rnd_ord_drain: entries left=%0d hold=%b after %0d cycles, want 0 0", q.size(), hold, cyc);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Random traffic on the pass-through instance against a busy-set model.
    task automatic test_random_ooo();
        int bl[$];
        logic [63:0]  mm [8];
        logic [1:0]   mw [8];
        logic         ms [8], me [8];
        bit           bz [8];
        logic [4:0]   acc_f [4];
        logic         acc_h [4];
        int cyc, nb, et;
        bit hold, drain, req_fire, fire, exp_we;
        logic [1:0] w;
        logic [4:0] f;
        logic hh;
        do_reset();
        hold = 0; cyc = 0;
        foreach (acc_f[i]) begin acc_f[i] = '0; acc_h[i] = 1'b0; end
        foreach (bz[i]) bz[i] = 1'b0;
        nb = 0;
        while ((cyc < 600 || hold || nb > 0) && cyc < 900) begin
            drain = (cyc >= 600);
            @(negedge clk);
            if (!hold) begin
                b_req_valid = !drain && ($urandom_range(0, 99) < 55);
                b_req_meta  = {$urandom, $urandom};
                b_req_wid   = 2'($urandom_range(0, 3));
                b_req_sop   = 1'($urandom_range(0, 1));
                b_req_eop   = 1'($urandom_range(0, 1));
            end
            bl.delete();
            foreach (bz[i]) if (bz[i]) bl.push_back(i);
            b_exe_valid = (bl.size() > 0) && (drain || $urandom_range(0, 99) < 60);
            b_exe_tag = '0;
            if (b_exe_valid) b_exe_tag = 3'(bl[$urandom_range(0, bl.size() - 1)]);
            b_exe_result     = {$urandom, $urandom, $urandom, $urandom};
            b_exe_has_fflags = 1'($urandom_range(0, 1));
            b_exe_fflags     = 5'($urandom_range(0, 31));
            b_cmt_ready      = drain || ($urandom_range(0, 99) < 70);
            #1;
            nb = bl.size();
            n_vec++;
            if (b_req_ready !== (nb < 8) || b_count !== 4'(nb) || b_exe_ready !== b_cmt_ready || b_cmt_valid !== b_exe_valid) begin
                n_err++;
                $display("FAIL rnd_ooo_hs cyc%0d: ready=%b count=%0d exe_ready=%b cmt_valid=%b, want %b %0d %b %b",
                         cyc, b_req_ready, b_count, b_exe_ready, b_cmt_valid, nb < 8, nb, b_cmt_ready, b_exe_valid);
            end
            req_fire = b_req_valid && (nb < 8);
            et = 0;
            for (int i = 7; i >= 0; i--) if (!bz[i]) et = i;
            if (req_fire) begin
                n_vec++;
                if (b_req_tag !== 3'(et)) begin
                    n_err++;
                    $display("FAIL rnd_ooo_tag cyc%0d: tag=%0d want %0d", cyc, b_req_tag, et);
                end
            end
            if (b_exe_valid) begin
                n_vec++;
                if (b_cmt_result !== b_exe_result || b_cmt_meta !== mm[b_exe_tag] || b_cmt_wid !== mw[b_exe_tag] ||
                    b_cmt_sop !== ms[b_exe_tag] || b_cmt_eop !== me[b_exe_tag]) begin
                    n_err++;
                    $display("FAIL rnd_ooo_data cyc%0d tag%0d: meta=%h wid=%0d sop=%b eop=%b, want %h %0d %b %b",
                             cyc, b_exe_tag, b_cmt_meta, b_cmt_wid, b_cmt_sop, b_cmt_eop,
                             mm[b_exe_tag], mw[b_exe_tag], ms[b_exe_tag], me[b_exe_tag]);
                end
            end
            fire = b_exe_valid && b_cmt_ready;
            exp_we = 1'b0;
            w = '0; f = '0;
            if (fire) begin
                w  = mw[b_exe_tag];
                f  = acc_f[w] | (b_exe_has_fflags ? b_exe_fflags : 5'd0);
                hh = acc_h[w] | b_exe_has_fflags;
                exp_we = me[b_exe_tag] && hh;
                if (me[b_exe_tag]) begin acc_f[w] = '0; acc_h[w] = 1'b0; end
                else begin acc_f[w] = f; acc_h[w] = hh; end
                bz[b_exe_tag] = 1'b0;
                nb--;
            end
            n_vec++;
            if (b_csr_we !== exp_we || (exp_we && (b_csr_wid !== w || b_csr_fflags !== f))) begin
                n_err++;
                $display("FAIL rnd_ooo_csr cyc%0d: we=%b wid=%0d ff=%h, want %b %0d %h",
                         cyc, b_csr_we, b_csr_wid, b_csr_fflags, exp_we, w, f);
            end
            if (req_fire) begin
                mm[et] = b_req_meta; mw[et] = b_req_wid; ms[et] = b_req_sop; me[et] = b_req_eop;
                bz[et] = 1'b1;
                nb++;
            end
            hold = b_req_valid && !req_fire;
            cyc++;
        end
        n_vec++;
        if (hold || nb != 0) begin
            n_err++;
            $display("FAIL rnd_ooo_drain: busy left=%0d hold=%b after %0d cycles, want 0 0", nb, hold, cyc);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_reorder();
        test_full_wrap();
        test_fflags();
        test_no_fflags();
        test_ooo_backpressure();
        test_random_inorder();
        test_random_ooo();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
